serial_gel_compare: RTL and testbench

Bit-serial magnitude comparator that produces the 3-bit one-hot GEL (Greater/Equal/Less) code consumed by `seg_display`. It sits directly upstream of the display stage. It latches two WIDTH-bit operands on a start strobe and scans them MSB-first, one bit per clock, terminating early at the first differing bit. It then holds the result on GEL until the next comparison completes. Both unsigned and two's-complement comparison are supported.

---
 rtl/gel_pkg.sv | 18 +
 rtl/serial_gel_compare_if.sv | 32 +++
 rtl/serial_gel_compare.sv | 130 +++++++++++++
 tb/tb_serial_gel_compare.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/gel_pkg.sv
// gel_pkg
// Shared constants for the bit-serial GEL comparator: the one-hot GEL result
// codes (as consumed by seg_display) and the comparator FSM state encoding.
// No ports.
package gel_pkg;

  localparam logic [2:0] GEL_G    = 3'b100;
  localparam logic [2:0] GEL_E    = 3'b010;
  localparam logic [2:0] GEL_L    = 3'b001;
  localparam logic [2:0] GEL_NONE = 3'b000;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

endpackage

// File: rtl/serial_gel_compare_if.sv
// serial_gel_compare_if
// Request/result bundle of the serial GEL comparator.
//   start     : single-cycle compare request (sampled in IDLE only)
//   SGN       : 1 = two's-complement, 0 = unsigned (latched with start)
//   A, B      : WIDTH-bit operands (latched with start)
//   GEL       : registered one-hot result {gt, eq, lt}, 3'b000 = none yet
//   done      : one-cycle pulse in the first cycle a new GEL is visible
//   busy      : high while the compare is running (SHIFT and DONE)
// master = requester, slave = comparator.
interface serial_gel_compare_if #(
  parameter int WIDTH = 8
) ();

  logic             start;
  logic             SGN;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic [2:0]       GEL;
  logic             done;
  logic             busy;

  modport master (
    output start, SGN, A, B,
    input  GEL, done, busy
  );

  modport slave (
    input  start, SGN, A, B,
    output GEL, done, busy
  );

endinterface

// File: rtl/serial_gel_compare.sv
// serial_gel_compare
// Bit-serial magnitude comparator. Latches A, B and SGN on start, then scans
// the operands MSB-first one bit per clock, stopping at the first differing
// bit (or after bit 0 when equal). The one-hot GEL result is held until the
// next compare completes.
// Ports:
//   clk  : system clock, rising edge
//   rst  : synchronous active-high reset (aborts a running compare)
//   bus  : serial_gel_compare_if.slave (start/SGN/A/B in, GEL/done/busy out)
//
// state | meaning
// IDLE  | waiting for start; GEL holds the last result
// SHIFT | comparing bit idx of the latched operands
// DONE  | one cycle after a decision; done is high, start ignored
module serial_gel_compare
  import gel_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input logic                 clk,
  input logic                 rst,
  serial_gel_compare_if.slave bus
);

  localparam int               IDX_W   = $clog2(WIDTH);
  localparam logic [IDX_W-1:0] IDX_MSB = IDX_W'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             sgn_q, sgn_d;
  logic [2:0]       gel_q, gel_d;
  logic             done_q, done_d;
  logic             busy_q, busy_d;

  logic             a_bit;
  logic             b_bit;
  logic             decide;
  logic [2:0]       result;

  // Bit compare at the current index. Only meaningful while in SHIFT.
  always_comb begin
    a_bit  = a_q[idx_q];
    b_bit  = b_q[idx_q];
    decide = 1'b0;
    result = GEL_NONE;
    if (a_bit != b_bit) begin
      decide = 1'b1;
      // In signed mode a set sign bit means the operand is the smaller one.
      if (sgn_q && (idx_q == IDX_MSB)) begin
        result = a_bit ? GEL_L : GEL_G;
      end else begin
        result = a_bit ? GEL_G : GEL_L;
      end
    end else if (idx_q == '0) begin
      decide = 1'b1;
      result = GEL_E;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.start) state_d = SHIFT;
      SHIFT:   if (decide)    state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath and output next values
  always_comb begin
    a_d    = a_q;
    b_d    = b_q;
    sgn_d  = sgn_q;
    idx_d  = idx_q;
    gel_d  = gel_q;
    done_d = 1'b0;
    busy_d = (state_d != IDLE);
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          a_d   = bus.A;
          b_d   = bus.B;
          sgn_d = bus.SGN;
          idx_d = IDX_MSB;
        end
      end
      SHIFT: begin
        if (decide) begin
          gel_d  = result;
          done_d = 1'b1;
        end else begin
          idx_d = idx_q - 1'b1;
        end
      end
      default: ;
    endcase
  end

  // State and register update
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      sgn_q   <= 1'b0;
      gel_q   <= GEL_NONE;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sgn_q   <= sgn_d;
      gel_q   <= gel_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
    end
  end

  assign bus.GEL  = gel_q;
  assign bus.done = done_q;
  assign bus.busy = busy_q;

endmodule

// File: tb/tb_serial_gel_compare.sv
// tb_serial_gel_compare
// Directed bench for serial_gel_compare (WIDTH = 8). Expected GEL codes and
// decision edges come from a behavioural compare model and are queued when a
// compare is launched, then popped when done is seen.
module tb_serial_gel_compare;

  localparam int W = 8;

  typedef struct {
    logic [2:0] gel;
    int         dec_edge;
  } exp_t;

  logic clk;
  logic rst;
  int   errors;
  int   checks;
  logic [2:0] last_gel;
  exp_t sb[$];

  serial_gel_compare_if #(.WIDTH(W)) bus ();

  serial_gel_compare #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [2:0] model_gel(input logic [W-1:0] a, input logic [W-1:0] b,
                                           input logic s);
    if (s) begin
      if ($signed(a) > $signed(b)) return 3'b100;
      if ($signed(a) < $signed(b)) return 3'b001;
      return 3'b010;
    end
    if (a > b) return 3'b100;
    if (a < b) return 3'b001;
    return 3'b010;
  endfunction

  function automatic int model_edge(input logic [W-1:0] a, input logic [W-1:0] b);
    for (int i = W - 1; i >= 0; i--) begin
      if (a[i] != b[i]) return W - i;
    end
    return W;
  endfunction

  // Launch one compare and follow it to completion. scramble: random A/B/SGN
  // after the start edge. poke: pulse start with FF/00 during SHIFT and DONE.
  task automatic run_compare(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                             input logic s, input bit scramble, input bit poke);
    exp_t e;
    bit   found;
    int   dec;
    @(negedge clk);
    bus.A     = a;
    bus.B     = b;
    bus.SGN   = s;
    bus.start = 1'b1;
    sb.push_back('{model_gel(a, b, s), model_edge(a, b)});
    @(negedge clk);
    bus.start = 1'b0;
    check({tag, "_busy_e0"}, {31'd0, bus.busy}, 32'd1);
    found = 1'b0;
    dec   = 0;
    for (int n = 1; n <= W + 2 && !found; n++) begin
      if (scramble) begin
        bus.A   = W'($urandom);
        bus.B   = W'($urandom);
        bus.SGN = 1'($urandom);
      end
      if (poke) begin
        if (n == 3) begin
          bus.start = 1'b1;
          bus.A     = 8'hFF;
          bus.B     = 8'h00;
        end else begin
          bus.start = 1'b0;
        end
      end
      @(negedge clk);
      if (bus.done === 1'b1) begin
        found = 1'b1;
        dec   = n;
      end else begin
        check({tag, "_hold"}, {28'd0, bus.busy, bus.GEL}, {28'd0, 1'b1, last_gel});
      end
    end
    bus.start = 1'b0;
    check({tag, "_done_seen"}, {31'd0, found}, 32'd1);
    if (sb.size() > 0) begin
      e = sb.pop_front();
      if (found) begin
        check({tag, "_gel"}, {29'd0, bus.GEL}, {29'd0, e.gel});
        check({tag, "_edge"}, dec, e.dec_edge);
        check({tag, "_busy_done"}, {31'd0, bus.busy}, 32'd1);
        last_gel = e.gel;
        if (poke) begin
          bus.start = 1'b1;
          bus.A     = 8'hFF;
          bus.B     = 8'h00;
        end
        @(negedge clk);
        bus.start = 1'b0;
        check({tag, "_post1"}, {27'd0, bus.done, bus.busy, bus.GEL}, {27'd0, 2'b00, last_gel});
        repeat (2) begin
          @(negedge clk);
          check({tag, "_post2"}, {27'd0, bus.done, bus.busy, bus.GEL}, {27'd0, 2'b00, last_gel});
        end
      end
    end
  endtask

  initial begin
    errors    = 0;
    checks    = 0;
    last_gel  = 3'b000;
    rst       = 1'b1;
    bus.start = 1'b0;
    bus.SGN   = 1'b0;
    bus.A     = '0;
    bus.B     = '0;
    repeat (3) @(negedge clk);
    check("reset_state", {27'd0, bus.done, bus.busy, bus.GEL}, 32'd0);
    rst = 1'b0;

    run_compare("eq_5a",      8'h5A, 8'h5A, 1'b0, 1'b0, 1'b0);
    run_compare("msb_uns",    8'h80, 8'h7F, 1'b0, 1'b0, 1'b0);
    run_compare("msb_sgn",    8'h80, 8'h7F, 1'b1, 1'b0, 1'b0);
    run_compare("lsb_uns",    8'h12, 8'h13, 1'b0, 1'b0, 1'b0);
    run_compare("neg_pair",   8'hFE, 8'hFD, 1'b1, 1'b0, 1'b0);
    run_compare("busy_poke",  8'h01, 8'h01, 1'b0, 1'b0, 1'b1);
    run_compare("scramble",   8'hC3, 8'hC7, 1'b1, 1'b1, 1'b0);
    run_compare("scramble2",  8'h3C, 8'h24, 1'b0, 1'b1, 1'b0);

    // Abort a running compare with a one-cycle reset at edge 3.
    run_compare("rst_pre",    8'h09, 8'h03, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    bus.A     = 8'h10;
    bus.B     = 8'h10;
    bus.SGN   = 1'b0;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_busy_e2", {28'd0, bus.busy, bus.GEL}, {28'd0, 1'b1, 3'b100});
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    last_gel = 3'b000;
    check("rst_abort", {27'd0, bus.done, bus.busy, bus.GEL}, 32'd0);
    for (int i = 0; i < W + 2; i++) begin
      @(negedge clk);
      check("rst_no_done", {27'd0, bus.done, bus.busy, bus.GEL}, 32'd0);
    end
    run_compare("after_rst",  8'h00, 8'h01, 1'b0, 1'b0, 1'b0);

    // Reset and start in the same cycle: start is lost.
    @(negedge clk);
    rst       = 1'b1;
    bus.start = 1'b1;
    bus.A     = 8'h55;
    bus.B     = 8'hAA;
    @(negedge clk);
    rst       = 1'b0;
    bus.start = 1'b0;
    last_gel  = 3'b000;
    check("rst_start_same", {27'd0, bus.done, bus.busy, bus.GEL}, 32'd0);
    @(negedge clk);
    check("rst_start_idle", {27'd0, bus.done, bus.busy, bus.GEL}, 32'd0);

    for (int i = 0; i < 6; i++) begin
      logic [W-1:0] ra;
      logic [W-1:0] rb;
      logic         rs;
      ra = W'($urandom);
      rb = (i % 2 == 0) ? (ra ^ W'(1 << $urandom_range(0, W - 1))) : W'($urandom);
      rs = 1'($urandom);
      run_compare("random", ra, rb, rs, 1'b0, 1'b0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
